// File: rtl/jzjpcc_writeback_pkg.sv
// Shared types and helpers for the jzjpcc writeback/load stage.
// Load funct3 encodings, FSM states and byte-lane extraction.
package jzjpcc_writeback_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } load_funct3_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

    // nbytes is the real word width in bytes; data is zero-extended to 64 bits
    function automatic logic [7:0] getLane(
        input logic [63:0] data,
        input int          k,
        input logic        bigEndian,
        input int          nbytes = 8
    );
        logic [7:0] lane;
        if (bigEndian)
            lane = data[8*(nbytes-1-k) +: 8];
        else
            lane = data[8*k +: 8];
        return lane;
    endfunction

endpackage

// File: rtl/jzjpcc_load_align.sv
// Combinational load aligner: picks bytes from byteOffset upward,
// assembles them little-endian and sign/zero-extends per funct3.
module jzjpcc_load_align
    import jzjpcc_writeback_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit BIG_ENDIAN_MEM = 1'b1
) (
    input  logic [XLEN-1:0]           rawData,
    input  logic [2:0]                funct3,
    input  logic [$clog2(XLEN/8)-1:0] byteOffset,
    output logic [XLEN-1:0]           alignedData,
    output logic                      fault
);

    localparam int   NB    = XLEN / 8;
    localparam logic IS_64 = (XLEN == 64);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = '0;
        for (int i = 0; i < NB; i++) begin
            if (int'(byteOffset) + i < NB)
                shifted[8*i +: 8] = getLane(64'(rawData), int'(byteOffset) + i,
                                            BIG_ENDIAN_MEM, NB);
        end
    end

    always_comb begin
        alignedData = '0;
        fault       = 1'b0;
        case (funct3)
            F3_LB: alignedData = XLEN'($signed(shifted[7:0]));
            F3_LH: begin
                alignedData = XLEN'($signed(shifted[15:0]));
                fault       = byteOffset[0];
            end
            F3_LW: begin
                alignedData = XLEN'($signed(shifted[31:0]));
                fault       = (byteOffset[1:0] != 2'b00);
            end
            F3_LD: begin
                alignedData = shifted;
                fault       = !IS_64 || (byteOffset != '0);
            end
            F3_LBU: alignedData = XLEN'(shifted[7:0]);
            F3_LHU: begin
                alignedData = XLEN'(shifted[15:0]);
                fault       = byteOffset[0];
            end
            F3_LWU: begin
                alignedData = XLEN'(shifted[31:0]);
                fault       = !IS_64 || (byteOffset[1:0] != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/jzjpcc_writeback_lsu.sv
// Registered writeback stage with variable-latency load response handshake.
// Optional perf counters enabled by defining JZJPCC_WB_PERF_COUNTERS_EN.
module jzjpcc_writeback_lsu
    import jzjpcc_writeback_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit BIG_ENDIAN_MEM   = 1'b1,
    parameter int MAX_LOAD_LATENCY = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [4:0]                rdAddr,
    input  logic                      rdWriteEnable,
    input  logic                      rdSource,
    input  logic [XLEN-1:0]           aluResult,
    input  logic [2:0]                funct3,
    input  logic [$clog2(XLEN/8)-1:0] byteOffset,
    input  logic                      memRespValid,
    input  logic [XLEN-1:0]           memRespData,
    output logic [4:0]                rdAddr_writebackEnd,
    output logic [XLEN-1:0]           rd_writebackEnd,
    output logic                      rdWriteEnable_writebackEnd,
    output logic                      loadFault,
    output logic                      loadTimeout
`ifdef JZJPCC_WB_PERF_COUNTERS_EN
    ,
    output logic [31:0]               loadCount,
    output logic [31:0]               stallCycles
`endif
);

    localparam int         OFF_W     = $clog2(XLEN / 8);
    localparam logic [7:0] MAX_COUNT = 8'(MAX_LOAD_LATENCY);

    wb_state_e       state;
    logic [7:0]      wait_count;
    logic [4:0]      pend_addr;
    logic            pend_we;
    logic [2:0]      pend_funct3;
    logic [OFF_W-1:0] pend_offset;

    logic            accept;
    logic            is_load;
    logic            in_wait;
    logic            resp_done;
    logic            timeout_now;
    logic [2:0]      align_funct3;
    logic [OFF_W-1:0] align_offset;
    logic [XLEN-1:0] aligned;
    logic            align_fault;
    logic [4:0]      done_addr;
    logic            done_we;

    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            fault_now;

    assign in_wait      = (state == WAIT);
    assign inReady      = !in_wait;
    assign accept       = inValid && inReady;
    assign is_load      = accept && rdSource;
    assign align_funct3 = in_wait ? pend_funct3 : funct3;
    assign align_offset = in_wait ? pend_offset : byteOffset;
    assign done_addr    = in_wait ? pend_addr : rdAddr;
    assign done_we      = in_wait ? pend_we : rdWriteEnable;
    assign resp_done    = memRespValid && (is_load || in_wait);
    assign timeout_now  = in_wait && !memRespValid && (wait_count == MAX_COUNT);

    jzjpcc_load_align #(
        .XLEN           (XLEN),
        .BIG_ENDIAN_MEM (BIG_ENDIAN_MEM)
    ) u_align (
        .rawData     (memRespData),
        .funct3      (align_funct3),
        .byteOffset  (align_offset),
        .alignedData (aligned),
        .fault       (align_fault)
    );

    // ALU ops and completed loads are mutually exclusive in any cycle
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = rdAddr;
        wr_data   = aluResult;
        fault_now = 1'b0;
        unique case (1'b1)
            accept && !rdSource: begin
                wr_en = rdWriteEnable && (rdAddr != 5'd0);
            end
            resp_done: begin
                fault_now = align_fault;
                wr_en     = done_we && (done_addr != 5'd0) && !align_fault;
                wr_addr   = done_addr;
                wr_data   = aligned;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                      <= IDLE;
            wait_count                 <= 8'd0;
            pend_addr                  <= 5'd0;
            pend_we                    <= 1'b0;
            pend_funct3                <= 3'd0;
            pend_offset                <= '0;
            rdAddr_writebackEnd        <= 5'd0;
            rd_writebackEnd            <= '0;
            rdWriteEnable_writebackEnd <= 1'b0;
            loadFault                  <= 1'b0;
            loadTimeout                <= 1'b0;
        end else begin
            loadFault                  <= fault_now;
            rdWriteEnable_writebackEnd <= wr_en;
            if (wr_en) begin
                rdAddr_writebackEnd <= wr_addr;
                rd_writebackEnd     <= wr_data;
            end
            if (timeout_now)
                loadTimeout <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (is_load && !memRespValid) begin
                        state       <= WAIT;
                        wait_count  <= 8'd1;
                        pend_addr   <= rdAddr;
                        pend_we     <= rdWriteEnable;
                        pend_funct3 <= funct3;
                        pend_offset <= byteOffset;
                    end
                end
                WAIT: begin
                    if (memRespValid || timeout_now)
                        state <= IDLE;
                    else
                        wait_count <= wait_count + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef JZJPCC_WB_PERF_COUNTERS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            loadCount   <= 32'd0;
            stallCycles <= 32'd0;
        end else begin
            if (is_load)
                loadCount <= loadCount + 32'd1;
            if (in_wait)
                stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jzjpcc_writeback_lsu.sv
// Directed bench for jzjpcc_writeback_lsu: a 32-bit big-endian instance
// and a 64-bit little-endian instance, both with MAX_LOAD_LATENCY = 4.
module tb_jzjpcc_writeback_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        v32, v64;
    logic [4:0]  rdAddr;
    logic        rdWe, rdSrc, respValid;
    logic [2:0]  f3, off;
    logic [63:0] alu, data;

    logic        r32_ready, r32_we, r32_fault, r32_to;
    logic [4:0]  r32_addr;
    logic [31:0] r32_rd;
    logic        r64_ready, r64_we, r64_fault, r64_to;
    logic [4:0]  r64_addr;
    logic [63:0] r64_rd;
`ifdef JZJPCC_WB_PERF_COUNTERS_EN
    logic [31:0] lc32, sc32, lc64, sc64;
`endif

    int errors = 0;
    int checks = 0;
    logic [63:0] last32 = '0;
    logic [63:0] last64 = '0;

    always #5 clock = ~clock;

    jzjpcc_writeback_lsu #(
        .XLEN(32), .BIG_ENDIAN_MEM(1'b1), .MAX_LOAD_LATENCY(4)
    ) dut32 (
        .clock(clock), .reset(reset), .inValid(v32), .inReady(r32_ready),
        .rdAddr(rdAddr), .rdWriteEnable(rdWe), .rdSource(rdSrc),
        .aluResult(alu[31:0]), .funct3(f3), .byteOffset(off[1:0]),
        .memRespValid(respValid), .memRespData(data[31:0]),
        .rdAddr_writebackEnd(r32_addr), .rd_writebackEnd(r32_rd),
        .rdWriteEnable_writebackEnd(r32_we), .loadFault(r32_fault),
        .loadTimeout(r32_to)
`ifdef JZJPCC_WB_PERF_COUNTERS_EN
        , .loadCount(lc32), .stallCycles(sc32)
`endif
    );

    jzjpcc_writeback_lsu #(
        .XLEN(64), .BIG_ENDIAN_MEM(1'b0), .MAX_LOAD_LATENCY(4)
    ) dut64 (
        .clock(clock), .reset(reset), .inValid(v64), .inReady(r64_ready),
        .rdAddr(rdAddr), .rdWriteEnable(rdWe), .rdSource(rdSrc),
        .aluResult(alu), .funct3(f3), .byteOffset(off),
        .memRespValid(respValid), .memRespData(data),
        .rdAddr_writebackEnd(r64_addr), .rd_writebackEnd(r64_rd),
        .rdWriteEnable_writebackEnd(r64_we), .loadFault(r64_fault),
        .loadTimeout(r64_to)
`ifdef JZJPCC_WB_PERF_COUNTERS_EN
        , .loadCount(lc64), .stallCycles(sc64)
`endif
    );

    typedef struct {
        logic        sel64;
        logic [4:0]  addr;
        logic        we_in;
        logic        src;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] alu;
        logic [63:0] data;
        logic        exp_we;
        logic        exp_fault;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic sel64, input logic [4:0] addr, input logic we_in,
        input logic src, input logic [2:0] fn, input logic [2:0] o,
        input logic [63:0] a, input logic [63:0] d, input logic ew,
        input logic ef, input logic [63:0] er
    );
        vec_t v;
        v.sel64 = sel64; v.addr = addr; v.we_in = we_in; v.src = src;
        v.f3 = fn; v.off = o; v.alu = a; v.data = d;
        v.exp_we = ew; v.exp_fault = ef; v.exp_rd = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        v32 = !v.sel64; v64 = v.sel64;
        rdAddr = v.addr; rdWe = v.we_in; rdSrc = v.src;
        f3 = v.f3; off = v.off; alu = v.alu; data = v.data;
        respValid = v.src;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    localparam logic [63:0] D64 = 64'h8877665544332211;

    initial begin
        logic        act_we, act_fault;
        logic [63:0] act_rd;
        logic [4:0]  act_addr;

        v32 = 0; v64 = 0; rdAddr = 0; rdWe = 0; rdSrc = 0;
        f3 = 0; off = 0; alu = 0; data = 0; respValid = 0;

        vq.push_back(mk(0, 1, 1, 1, 3'b100, 3, 0, 64'h11223344, 1, 0, 64'h44));
        vq.push_back(mk(0, 2, 1, 1, 3'b001, 2, 0, 64'h11223344, 1, 0, 64'h4433));
        vq.push_back(mk(0, 3, 1, 1, 3'b010, 0, 0, 64'h11223344, 1, 0, 64'h44332211));
        vq.push_back(mk(0, 4, 1, 1, 3'b000, 0, 0, 64'h80000000, 1, 0, 64'hFFFFFF80));
        vq.push_back(mk(0, 5, 1, 1, 3'b101, 0, 0, 64'h8000FFFF, 1, 0, 64'h80));
        vq.push_back(mk(0, 6, 1, 1, 3'b001, 1, 0, 64'h11223344, 0, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 3'b000, 0, 64'h1234, 0, 0, 0, 0));
        vq.push_back(mk(0, 8, 1, 1, 3'b011, 0, 0, 64'h11223344, 0, 1, 0));
        vq.push_back(mk(0, 9, 1, 0, 3'b000, 0, 64'hCAFEBABE, 0, 1, 0, 64'hCAFEBABE));
        vq.push_back(mk(0, 10, 1, 1, 3'b010, 2, 0, 64'h11223344, 0, 1, 0));
        vq.push_back(mk(0, 11, 1, 1, 3'b111, 0, 0, 64'h11223344, 0, 1, 0));
        vq.push_back(mk(0, 12, 1, 1, 3'b110, 0, 0, 64'h11223344, 0, 1, 0));
        vq.push_back(mk(0, 13, 0, 0, 3'b000, 0, 64'h77, 0, 0, 0, 0));
        vq.push_back(mk(0, 14, 1, 1, 3'b100, 1, 0, 64'hA1B2C3D4, 1, 0, 64'hB2));
        vq.push_back(mk(0, 0, 1, 1, 3'b000, 0, 0, 64'h11223344, 0, 0, 0));
        vq.push_back(mk(1, 10, 1, 1, 3'b011, 0, 0, D64, 1, 0, D64));
        vq.push_back(mk(1, 11, 1, 1, 3'b110, 4, 0, D64, 1, 0, 64'h88776655));
        vq.push_back(mk(1, 12, 1, 1, 3'b010, 4, 0, D64, 1, 0, 64'hFFFFFFFF88776655));
        vq.push_back(mk(1, 13, 1, 1, 3'b000, 7, 0, D64, 1, 0, 64'hFFFFFFFFFFFFFF88));
        vq.push_back(mk(1, 14, 1, 1, 3'b011, 4, 0, D64, 0, 1, 0));
        vq.push_back(mk(1, 15, 1, 1, 3'b101, 6, 0, D64, 1, 0, 64'h8877));
        vq.push_back(mk(1, 16, 1, 1, 3'b001, 3, 0, D64, 0, 1, 0));
        vq.push_back(mk(1, 18, 1, 1, 3'b001, 6, 0, D64, 1, 0, 64'hFFFFFFFFFFFF8877));
        vq.push_back(mk(1, 17, 1, 0, 3'b000, 0, 64'h0123456789ABCDEF, 0, 1, 0,
                        64'h0123456789ABCDEF));

        repeat (3) @(posedge clock);
        #1;
        reset = 0;

        check("rst32_ready", r32_ready, 1);
        check("rst32_we", r32_we, 0);
        check("rst32_rd", {32'h0, r32_rd}, 0);
        check("rst32_addr", r32_addr, 0);
        check("rst32_fault", r32_fault, 0);
        check("rst32_to", r32_to, 0);
        check("rst64_ready", r64_ready, 1);
        check("rst64_rd", r64_rd, 0);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
            step();
            v32 = 0; v64 = 0; respValid = 0;
            if (vq[i].sel64) begin
                act_we = r64_we; act_fault = r64_fault;
                act_rd = r64_rd; act_addr = r64_addr;
            end else begin
                act_we = r32_we; act_fault = r32_fault;
                act_rd = {32'h0, r32_rd}; act_addr = r32_addr;
            end
            check($sformatf("vec%0d_we", i), act_we, vq[i].exp_we);
            check($sformatf("vec%0d_fault", i), act_fault, vq[i].exp_fault);
            if (vq[i].exp_we) begin
                check($sformatf("vec%0d_rd", i), act_rd, vq[i].exp_rd);
                check($sformatf("vec%0d_addr", i), act_addr, vq[i].addr);
                if (vq[i].sel64) last64 = vq[i].exp_rd;
                else last32 = vq[i].exp_rd;
            end else begin
                check($sformatf("vec%0d_hold", i), act_rd,
                      vq[i].sel64 ? last64 : last32);
            end
        end

        // load waits three cycles, response arrives on the third
        v32 = 1; rdAddr = 5'd20; rdWe = 1; rdSrc = 1; f3 = 3'b010; off = 0;
        respValid = 0; data = 0;
        step();
        v32 = 0;
        check("wait1_ready", r32_ready, 0);
        check("wait1_we", r32_we, 0);
        step();
        check("wait2_ready", r32_ready, 0);
        step();
        check("wait3_ready", r32_ready, 0);
        respValid = 1; data = 64'hDEADBEEF;
        step();
        respValid = 0;
        check("resp_we", r32_we, 1);
        check("resp_rd", {32'h0, r32_rd}, 64'hEFBEADDE);
        check("resp_addr", r32_addr, 20);
        check("resp_ready", r32_ready, 1);

        // no response: timeout after four WAIT cycles
        v32 = 1; rdAddr = 5'd21; rdWe = 1; rdSrc = 1; f3 = 3'b010; off = 0;
        respValid = 0;
        step();
        v32 = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_wait%0d_ready", i), r32_ready, 0);
            check($sformatf("to_wait%0d_to", i), r32_to, 0);
            step();
        end
        check("to_set", r32_to, 1);
        check("to_ready", r32_ready, 1);
        check("to_we", r32_we, 0);
        check("to_hold", {32'h0, r32_rd}, 64'hEFBEADDE);
        v32 = 1; rdAddr = 5'd7; rdWe = 1; rdSrc = 0; alu = 64'd5;
        step();
        v32 = 0;
        check("post_to_we", r32_we, 1);
        check("post_to_addr", r32_addr, 7);
        check("post_to_rd", {32'h0, r32_rd}, 5);
        check("to_sticky", r32_to, 1);

        // reset while a 64-bit load is pending
        v64 = 1; rdAddr = 5'd22; rdWe = 1; rdSrc = 1; f3 = 3'b011; off = 0;
        respValid = 0;
        step();
        v64 = 0;
        check("rw_wait_ready", r64_ready, 0);
        reset = 1;
        step();
        reset = 0;
        check("rw_ready", r64_ready, 1);
        check("rw_we", r64_we, 0);
        check("rw_addr", r64_addr, 0);
        check("rw_rd", r64_rd, 0);
        check("rw_fault", r64_fault, 0);
        check("rw_to", r64_to, 0);
        check("rw32_to_clear", r32_to, 0);
        respValid = 1; data = D64;
        step();
        respValid = 0;
        check("idle_resp_we", r64_we, 0);
        check("idle_resp_ready", r64_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
